// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and types for the RV32M multiply/divide sequencer
package muldiv_pkg;

   // RV32M funct3 encodings
   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   // funct7 that routes an OP instruction to this unit instead of the ALU
   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   // Quotient returned for a zero divisor
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with valid/ready handshakes
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_valid_i,
   output logic            start_ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   state_t state, state_nx;

   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic            neg_q;
   logic [XLEN-1:0] opm_q;    // multiplicand for MUL*, divisor magnitude for DIV*/REM*
   logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
   logic [XLEN-1:0] acc_lo;   // multiplier being shifted out / quotient being shifted in
   logic [XLEN-1:0] res_q;

   logic            accept;
   logic            is_mul;
   logic            a_signed, b_signed, sa, sb;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div0, ovf, special;
   logic [XLEN-1:0] special_res;
   logic            neg_in;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;
   logic              div_ge;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   // Decode the incoming request: signedness, magnitudes and the no-iteration cases
   always_comb begin
      accept      = start_valid_i && (state == IDLE) && !flush_i;
      is_mul      = !funct3_i[2];
      a_signed    = (funct3_i == MULH) || (funct3_i == MULHSU) || (funct3_i == DIV) || (funct3_i == REM);
      b_signed    = (funct3_i == MULH) || (funct3_i == DIV) || (funct3_i == REM);
      sa          = a_signed && op_a_i[XLEN-1];
      sb          = b_signed && op_b_i[XLEN-1];
      a_mag       = sa ? -op_a_i : op_a_i;
      b_mag       = sb ? -op_b_i : op_b_i;
      neg_in      = (is_mul || !funct3_i[1]) ? (sa ^ sb) : sa;
      div0        = !is_mul && (op_b_i == '0);
      ovf         = !is_mul && !funct3_i[0]
                    && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
      special     = div0 || ovf;
      special_res = '0;
      if (div0) begin
         special_res = funct3_i[1] ? op_a_i : DIV_ZERO_Q;
      end else if (ovf) begin
         special_res = funct3_i[1] ? '0 : op_a_i;
      end
   end

   // One shift-add or restoring-division step, plus the sign fix-up of the finished values
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opm_q} : '0);
      div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opm_q};
      div_ge    = !div_trial[XLEN];
      prod_s    = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo_s     = neg_q ? -acc_lo : acc_lo;
      rem_s     = neg_q ? -acc_hi : acc_hi;
      case (f3_q)
         MUL:                  fix_res = prod_s[XLEN-1:0];
         MULH, MULHSU, MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
         DIV, DIVU:            fix_res = quo_s;
         default:              fix_res = rem_s;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic and handshake outputs; flush always wins
   always_comb begin
      state_nx       = state;
      start_ready_o  = 1'b0;
      result_valid_o = 1'b0;
      busy_o         = 1'b1;
      case (state)
         IDLE: begin
            start_ready_o = 1'b1;
            busy_o        = 1'b0;
            if (accept) state_nx = special ? DONE : CALC;
         end
         CALC: begin
            if (flush_i)              state_nx = IDLE;
            else if (cnt == CNT_LAST) state_nx = FIX;
         end
         FIX: begin
            state_nx = flush_i ? IDLE : DONE;
         end
         DONE: begin
            result_valid_o = 1'b1;
            if (flush_i || result_ready_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch on acceptance, iteration in CALC, result capture in FIX
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         f3_q   <= '0;
         neg_q  <= 1'b0;
         opm_q  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         res_q  <= '0;
      end else if (accept) begin
         cnt    <= '0;
         f3_q   <= funct3_i;
         neg_q  <= neg_in;
         opm_q  <= is_mul ? a_mag : b_mag;
         acc_hi <= '0;
         acc_lo <= is_mul ? b_mag : a_mag;
         if (special) res_q <= special_res;
      end else if (state == CALC && !flush_i) begin
         cnt <= cnt + 1'b1;
         if (!f3_q[2]) begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
         end else begin
            acc_hi <= div_ge ? div_trial[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
         end
      end else if (state == FIX && !flush_i) begin
         res_q <= fix_res;
      end
   end

   assign result_o = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for the multiply/divide sequencer
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_valid_i = 1'b0;
   logic        start_ready_o;
   logic [2:0]  funct3_i = 3'b000;
   logic [31:0] op_a_i = '0;
   logic [31:0] op_b_i = '0;
   logic        flush_i = 1'b0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b1;
   logic [31:0] result_o;
   logic        busy_o;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_q[$];
   int          lat_q[$];

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start_valid_i  (start_valid_i),
      .start_ready_o  (start_ready_o),
      .funct3_i       (funct3_i),
      .op_a_i         (op_a_i),
      .op_b_i         (op_b_i),
      .flush_i        (flush_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sb, sq, sr;
      logic               ov;
      sa = a;
      sb = b;
      ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      sq = '0;
      sr = '0;
      if (b != 0 && !ov) begin
         sq = sa / sb;
         sr = sa % sb;
      end
      case (f3)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; model = p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; model = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; model = p[63:32]; end
         3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : sq;
         3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: model = (b == 0) ? a : ov ? 32'h0 : sr;
         default: model = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      return 34;
   endfunction

   // Issue one operation, then check the result, its latency and the handshake afterwards
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
      int          lat;
      logic [31:0] exp_r;
      int          exp_l;
      exp_q.push_back(model(f3, a, b));
      lat_q.push_back(model_lat(f3, a, b));
      @(negedge clk);
      start_valid_i  = 1'b1;
      funct3_i       = f3;
      op_a_i         = a;
      op_b_i         = b;
      result_ready_i = (hold == 0);
      @(posedge clk);
      #1;
      start_valid_i = 1'b0;
      op_a_i        = $urandom;
      op_b_i        = $urandom;
      funct3_i      = 3'($urandom_range(0, 7));
      lat = 1;
      while (!result_valid_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      exp_r = exp_q.pop_front();
      exp_l = lat_q.pop_front();
      vectors++;
      if (!result_valid_o) begin
         miscompares++;
         $display("FAIL op_timeout f3=%0d a=%h b=%h: no result_valid_o within %0d cycles", f3, a, b, lat);
         result_ready_i = 1'b1;
         return;
      end
      vectors++;
      if (result_o !== exp_r) begin
         miscompares++;
         $display("FAIL result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, result_o, exp_r);
      end
      vectors++;
      if (lat != exp_l) begin
         miscompares++;
         $display("FAIL latency f3=%0d a=%h b=%h: got %0d expected %0d", f3, a, b, lat, exp_l);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (result_valid_o !== 1'b1 || result_o !== exp_r || start_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_hold cycle %0d: valid=%b result=%h ready=%b busy=%b expected 1 %h 0 1",
                     i, result_valid_o, result_o, start_ready_o, busy_o, exp_r);
         end
      end
      if (hold > 0) begin
         @(negedge clk);
         result_ready_i = 1'b1;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (result_valid_o !== 1'b0 || start_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL drain f3=%0d: valid=%b start_ready=%b expected 0 1", f3, result_valid_o, start_ready_o);
      end
   endtask

   task automatic test_reset;
      #1;
      vectors++;
      if (start_ready_o !== 1'b1 || result_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: ready=%b valid=%b result=%h busy=%b expected 1 0 0 0",
                  start_ready_o, result_valid_o, result_o, busy_o);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_mul;
      do_op(MUL,    32'h0000_0007, 32'hFFFF_FFFD, 0);
      do_op(MULH,   32'h8000_0000, 32'h8000_0000, 0);
      do_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_div;
      do_op(DIV,  32'hFFFF_FFF9, 32'h0000_0002, 0);
      do_op(REM,  32'hFFFF_FFF9, 32'h0000_0002, 0);
      do_op(DIVU, 32'd100, 32'd7, 0);
      do_op(REMU, 32'd100, 32'd7, 0);
   endtask

   task automatic test_special;
      do_op(DIVU, 32'd5, 32'd0, 0);
      do_op(REMU, 32'd5, 32'd0, 0);
      do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_flush;
      logic seen;
      @(negedge clk);
      start_valid_i = 1'b1;
      funct3_i      = MUL;
      op_a_i        = 32'd1234;
      op_b_i        = 32'd5678;
      @(posedge clk);
      #1;
      start_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      vectors++;
      if (start_ready_o !== 1'b1 || busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_idle: ready=%b busy=%b valid=%b expected 1 0 0", start_ready_o, busy_o, result_valid_o);
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (result_valid_o) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_no_result: result_valid_o rose %b expected 0", seen);
      end
      // flush while idle must block a simultaneous request
      @(negedge clk);
      flush_i       = 1'b1;
      start_valid_i = 1'b1;
      funct3_i      = DIVU;
      op_b_i        = 32'd0;
      @(posedge clk);
      #1;
      flush_i       = 1'b0;
      start_valid_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_priority: busy=%b valid=%b expected 0 0", busy_o, result_valid_o);
      end
      do_op(MUL, 32'd3, 32'd4, 0);
   endtask

   task automatic test_backpressure;
      do_op(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5);
      do_op(REMU, 32'd9, 32'd0, 5);
   endtask

   task automatic test_async_reset;
      logic seen;
      @(negedge clk);
      start_valid_i = 1'b1;
      funct3_i      = DIV;
      op_a_i        = 32'd1000;
      op_b_i        = 32'd3;
      @(posedge clk);
      #1;
      start_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (start_ready_o !== 1'b1 || result_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: ready=%b valid=%b result=%h busy=%b expected 1 0 0 0",
                  start_ready_o, result_valid_o, result_o, busy_o);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (result_valid_o) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abandon: result_valid_o rose %b expected 0", seen);
      end
      do_op(DIV, 32'd1000, 32'd3, 0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      logic [2:0]  f3;
      for (int i = 0; i < 12; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 4 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
         do_op(f3, a, b, 0);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits in EX beside the single-cycle ALU and is selected for OP opcodes with funct7 = 0000001.
- Accepts one operation at a time via a valid/ready handshake and returns the result via a valid/ready handshake.
- The pipeline stalls EX while start_ready_o or result_valid_o is low for an issued M-instruction.

Parameters:
XLEN, 32, operand/result width; the counter is $clog2(XLEN) bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
start_valid_i  input  1  operation request.
start_ready_o  output  1  unit idle; can accept a request.
funct3_i  input  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
op_a_i  input  XLEN  rs1 value (multiplicand/dividend).
op_b_i  input  XLEN  rs2 value (multiplier/divisor).
flush_i  input  1  kill the in-flight operation (branch/exception flush).
result_valid_o  output  1  result available.
result_ready_i  input  1  consumer takes the result.
result_o  output  XLEN  result.
busy_o  output  1  state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; counter = 0; all internal registers cleared.
  - start_ready_o = 1, result_valid_o = 0, result_o = 0, busy_o = 0.
  - Reset mid-operation abandons the operation and produces no result.
- Acceptance: start_valid_i && start_ready_o at a rising edge (edge E0).
  - On acceptance, latch funct3, operand magnitudes and result sign.
  - Operands are not sampled at any other time.
- States:
  - IDLE: start_ready_o = 1.
    - Accept with special case -> DONE.
    - Accept otherwise -> CALC, counter = 0.
  - CALC: one iteration per cycle; counter increments.
    - Counter = XLEN-1 -> FIX.
    - MUL*: shift-add on unsigned magnitudes into a 2*XLEN product register.
    - DIV*/REM*: restoring division, one quotient bit per cycle.
  - FIX: apply the sign correction (two's-complement negate where required) and select the low half, high half, quotient or remainder into the result register -> DONE.
  - DONE: result_valid_o = 1 and result_o held stable.
    - result_ready_i high -> IDLE.
    - A new start is not accepted in the same cycle.
- Latency:
  - Normal operations: result_valid_o rises XLEN+2 cycles after the acceptance cycle (34 for XLEN = 32).
  - Special cases: result_valid_o rises 1 cycle after the acceptance cycle.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: low XLEN bits, identical for all signedness.
- Division rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Special cases (no iteration):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- flush_i:
  - In CALC, FIX or DONE: next state IDLE, result_valid_o low the next cycle, no result delivered.
  - In IDLE, flush_i has priority over start_valid_i: the request is not accepted.
- Backpressure: while in DONE with result_ready_i low, result_o and result_valid_o are held indefinitely.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams: MUL = 3'b000 through REMU = 3'b111.
  - FSM state enum {IDLE, CALC, FIX, DONE}.
  - DIV_ZERO_Q constant (all ones).
  - M-extension funct7 constant 7'b0000001 for the decoder/ALU-control path.
  - XLEN comes from the existing global defines header.
- Single module. The iteration datapath stays inline; no sub-module is warranted.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid at cycle +34; MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each valid 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush in CALC at counter = 10 -> result_valid_o never rises, start_ready_o = 1 the next cycle; a following MUL 3x4 returns 12.
- result_ready_i held low 5 cycles in DONE -> result_o stable, start_ready_o = 0 throughout; reset_n pulsed mid-CALC -> all outputs at reset values immediately (asynchronously).
